// File: rtl/piso_serial_tx.sv
// -----------------------------------------------------------------------------
// piso_serial_tx
//
// Parallel-in / serial-out transmitter. A WIDTH-bit word is captured on a load
// strobe while the block is idle and is then presented one bit per clock on
// sd, with sen marking every valid bit, so that a downstream chain of enabled
// D flip-flops (d <- sd, en <- sen) can capture it. A single-cycle done pulse
// follows the last bit, after which the block returns to idle.
//
// Parameters
//   WIDTH     : data word width in bits (must be >= 2)
//   MSB_FIRST : 1 = bit WIDTH-1 is sent first, 0 = bit 0 is sent first
//
// Optional build macro
//   PISO_PARITY_EN : when defined, one extra bit carrying even parity of the
//                    captured word (XOR of all data bits) follows the last
//                    data bit, still qualified by sen. When undefined no
//                    parity register or logic exists.
//
// Ports
//   clk     in   1      system clock, all logic on the rising edge
//   reset   in   1      synchronous, active-high reset
//   load    in   1      request to send data_in, honoured only while ready=1
//   data_in in   WIDTH  parallel word to transmit
//   ready   out  1      idle, a load will be accepted
//   busy    out  1      shifting or signalling done
//   sd      out  1      serial data bit towards the downstream d input
//   sen     out  1      bit-valid strobe towards the downstream en input
//   done    out  1      one-cycle pulse after the last bit was presented
// -----------------------------------------------------------------------------
module piso_serial_tx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  output logic             ready,
  output logic             busy,
  output logic             sd,
  output logic             sen,
  output logic             done
);

  // State encoding kept as plain constants so the block drops into older
  // flows that do not understand enumerated types.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Number of sen-qualified bits per word; the parity build appends one.
`ifdef PISO_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif

  // The counter is sized for WIDTH+2 so that it can hold NBITS (its value
  // after the last shift) in either build without ever wrapping.
  localparam int              CNT_W    = $clog2(WIDTH + 2);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBITS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_shift;
  logic [CNT_W-1:0] r_count;

  logic             w_head;
  logic [WIDTH-1:0] w_shiftNext;
  logic             w_serialBit;
  logic             w_lastBit;

  // The head of the shift register is whichever end leaves first; each
  // shift moves the next bit into the head position and back-fills with 0,
  // so a partially sent word never re-emits stale data.
  generate
    if (MSB_FIRST) begin : gMsbFirst
      assign w_head      = r_shift[WIDTH-1];
      assign w_shiftNext = {r_shift[WIDTH-2:0], 1'b0};
    end else begin : gLsbFirst
      assign w_head      = r_shift[0];
      assign w_shiftNext = {1'b0, r_shift[WIDTH-1:1]};
    end
  endgenerate

  assign w_lastBit = (r_count == LAST_CNT);

`ifdef PISO_PARITY_EN
  logic r_parity;

  // Parity is computed from data_in at the moment of capture and held, so
  // the bit sent after the data does not depend on the (by then empty)
  // shift register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_parity <= 1'b0;
    end else if ((r_state == ST_IDLE) && load) begin
      r_parity <= ^data_in;
    end
  end

  // Once all WIDTH data bits have left, the counter equals WIDTH and the
  // serial line carries the held parity bit instead of the register head.
  assign w_serialBit = (r_count == CNT_W'(WIDTH)) ? r_parity : w_head;
`else
  assign w_serialBit = w_head;
`endif

  // Main sequencer. IDLE waits for a load and captures the word, SHIFT
  // advances one bit per clock until the last bit has been shown, DONE lasts
  // exactly one cycle. Reset takes priority over everything, including a
  // simultaneous load, and throws away any partial word without a done.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (load) begin
            r_shift <= data_in;
            r_count <= '0;
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_shift <= w_shiftNext;
          r_count <= r_count + CNT_ONE;
          if (w_lastBit) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // All outputs are decoded purely from registered state, so nothing on
  // load or data_in can reach them combinationally. sd is forced low
  // outside SHIFT so the line is quiet whenever sen is low.
  assign ready = (r_state == ST_IDLE);
  assign busy  = (r_state == ST_SHIFT) || (r_state == ST_DONE);
  assign sen   = (r_state == ST_SHIFT);
  assign done  = (r_state == ST_DONE);
  assign sd    = (r_state == ST_SHIFT) && w_serialBit;

endmodule

// File: tb/tb_piso_serial_tx.sv
// -----------------------------------------------------------------------------
// tb_piso_serial_tx
//
// Drives an MSB-first and an LSB-first instance of piso_serial_tx (WIDTH=8)
// with identical inputs. A table of per-cycle records holds the inputs that
// are present across one rising edge and the outputs expected right after
// that edge. Multi-cycle corner cases are covered by short hand-written
// sequences. Builds with or without PISO_PARITY_EN.
// -----------------------------------------------------------------------------
module tb_piso_serial_tx;

`ifdef PISO_PARITY_EN
  localparam int NBITS = 9;
`else
  localparam int NBITS = 8;
`endif

  logic       clk;
  logic       reset;
  logic       load;
  logic [7:0] dataIn;

  logic readyM, busyM, sdM, senM, doneM;
  logic readyL, busyL, sdL, senL, doneL;

  int testsRun;
  int testsFailed;

  typedef struct {
    logic       rst;
    logic       ld;
    logic [7:0] data;
    logic       expReady;
    logic       expBusy;
    logic       expSen;
    logic       expSdMsb;
    logic       expSdLsb;
    logic       expDone;
  } vec_t;

  vec_t vecs[$];

  piso_serial_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) dutMsb (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .data_in (dataIn),
    .ready   (readyM),
    .busy    (busyM),
    .sd      (sdM),
    .sen     (senM),
    .done    (doneM)
  );

  piso_serial_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) dutLsb (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .data_in (dataIn),
    .ready   (readyL),
    .busy    (busyL),
    .sd      (sdL),
    .sen     (senL),
    .done    (doneL)
  );

  // Free-running 10-time-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Append one per-cycle record to the table.
  task automatic push(input logic rst, input logic ld, input logic [7:0] data,
                      input logic rdy, input logic bsy, input logic se,
                      input logic sdm, input logic sdl, input logic dn);
    vec_t v;
    v.rst = rst; v.ld = ld; v.data = data;
    v.expReady = rdy; v.expBusy = bsy; v.expSen = se;
    v.expSdMsb = sdm; v.expSdLsb = sdl; v.expDone = dn;
    vecs.push_back(v);
  endtask

  // Append a full word: the load edge, the remaining shift cycles, the
  // optional parity cycle, the done cycle and the return to idle.
  // msbBits/lsbBits list the expected serial bits in send order, first bit
  // in position 7. holdLoad keeps load high after the accepting edge.
  task automatic pushWord(input logic [7:0] data, input logic [7:0] msbBits,
                          input logic [7:0] lsbBits, input logic parityBit,
                          input logic holdLoad);
    for (int i = 0; i < 8; i++) begin
      push(1'b0, (i == 0) ? 1'b1 : holdLoad, data,
           1'b0, 1'b1, 1'b1, msbBits[7-i], lsbBits[7-i], 1'b0);
    end
`ifdef PISO_PARITY_EN
    push(1'b0, holdLoad, data, 1'b0, 1'b1, 1'b1, parityBit, parityBit, 1'b0);
`else
    if (parityBit) begin end
`endif
    push(1'b0, holdLoad, data, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    push(1'b0, holdLoad, data, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // One comparison; a mismatch prints a single FAIL line.
  task automatic checkOutput(input string name, input int idx,
                             input logic act, input logic exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s step %0d: got %b, expected %b", name, idx, act, exp);
    end
  endtask

  // Hold the given inputs across one rising edge, then let outputs settle.
  task automatic stepInputs(input logic rst, input logic ld, input logic [7:0] data);
    @(negedge clk);
    reset  = rst;
    load   = ld;
    dataIn = data;
    @(posedge clk);
    #1;
  endtask

  // Apply one table record and compare every output of both instances.
  task automatic applyStimulus(input vec_t v, input int idx);
    stepInputs(v.rst, v.ld, v.data);
    checkOutput("msb.ready", idx, readyM, v.expReady);
    checkOutput("msb.busy",  idx, busyM,  v.expBusy);
    checkOutput("msb.sen",   idx, senM,   v.expSen);
    checkOutput("msb.sd",    idx, sdM,    v.expSdMsb);
    checkOutput("msb.done",  idx, doneM,  v.expDone);
    checkOutput("lsb.ready", idx, readyL, v.expReady);
    checkOutput("lsb.busy",  idx, busyL,  v.expBusy);
    checkOutput("lsb.sen",   idx, senL,   v.expSen);
    checkOutput("lsb.sd",    idx, sdL,    v.expSdLsb);
    checkOutput("lsb.done",  idx, doneL,  v.expDone);
  endtask

  initial begin
    int   cycles;
    int   senCount;
    bit   seenDone;
    logic overlap;

    testsRun    = 0;
    testsFailed = 0;
    reset  = 1'b0;
    load   = 1'b0;
    dataIn = 8'h00;

    // Reset held two cycles with load high and all-ones data: stays idle,
    // then load dropped and still idle.
    push(1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push(1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push(1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // A5 is a bit palindrome; 01 differs by order; 07 has odd parity.
    pushWord(8'hA5, 8'b10100101, 8'b10100101, 1'b0, 1'b0);
    pushWord(8'h01, 8'b00000001, 8'b10000000, 1'b1, 1'b0);
    pushWord(8'h07, 8'b00000111, 8'b11100000, 1'b1, 1'b0);

    // Load 0F, then a load pulse with F0 in the fourth shift cycle, which
    // must be ignored.
    for (int i = 0; i < 8; i++) begin
      logic [7:0] mb;
      logic [7:0] lb;
      mb = 8'b00001111;
      lb = 8'b11110000;
      push(1'b0, (i == 0) || (i == 3), (i == 3) ? 8'hF0 : 8'h0F,
           1'b0, 1'b1, 1'b1, mb[7-i], lb[7-i], 1'b0);
    end
`ifdef PISO_PARITY_EN
    push(1'b0, 1'b0, 8'h0F, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
`endif
    push(1'b0, 1'b0, 8'h0F, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    push(1'b0, 1'b0, 8'h0F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push(1'b0, 1'b0, 8'hF0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset in the fourth shift cycle of FF: idle at once, no done after.
    for (int i = 0; i < 4; i++) begin
      push(1'b0, (i == 0), 8'hFF, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    end
    push(1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push(1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    pushWord(8'h81, 8'b10000001, 8'b10000001, 1'b0, 1'b0);

    // Load held high: the second word is accepted on the first idle cycle.
    pushWord(8'h3C, 8'b00111100, 8'b00111100, 1'b0, 1'b1);
    pushWord(8'hC3, 8'b11000011, 8'b11000011, 1'b0, 1'b0);

    foreach (vecs[k]) begin
      applyStimulus(vecs[k], k);
    end

    // Bounded wait for done after a load: done must arrive NBITS+1 cycles
    // after the accepting edge, with exactly NBITS sen cycles, never
    // overlapping done.
    stepInputs(1'b0, 1'b1, 8'h5A);
    cycles   = 1;
    senCount = senM ? 1 : 0;
    seenDone = 1'b0;
    overlap  = 1'b0;
    while (!seenDone && cycles < 40) begin
      stepInputs(1'b0, 1'b0, 8'h00);
      cycles++;
      if (senM) senCount++;
      if (senM && doneM) overlap = 1'b1;
      if (doneM) seenDone = 1'b1;
    end
    checkOutput("wait.doneSeen", 0, seenDone, 1'b1);
    testsRun++;
    if (cycles != NBITS + 1) begin
      testsFailed++;
      $display("[TB] FAIL wait.doneLatency: got %0d cycles, expected %0d", cycles, NBITS + 1);
    end
    testsRun++;
    if (senCount != NBITS) begin
      testsFailed++;
      $display("[TB] FAIL wait.senCount: got %0d, expected %0d", senCount, NBITS);
    end
    checkOutput("wait.senDoneOverlap", 0, overlap, 1'b0);
    stepInputs(1'b0, 1'b0, 8'h00);
    checkOutput("wait.readyAfter", 0, readyM, 1'b1);

    // Reset during the very last sen cycle: no done pulse must follow.
    stepInputs(1'b0, 1'b1, 8'hFF);
    for (int i = 1; i < NBITS; i++) begin
      stepInputs(1'b0, 1'b0, 8'h00);
    end
    checkOutput("lastBit.sen", 0, senM, 1'b1);
    stepInputs(1'b1, 1'b0, 8'h00);
    checkOutput("lastBit.readyOnReset", 0, readyM, 1'b1);
    checkOutput("lastBit.doneOnReset",  0, doneM,  1'b0);
    checkOutput("lastBit.senOnReset",   0, senM,   1'b0);
    stepInputs(1'b0, 1'b0, 8'h00);
    checkOutput("lastBit.doneAfter",  0, doneM,  1'b0);
    checkOutput("lastBit.readyAfter", 0, readyM, 1'b1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
